// File: rtl/regfile_pkg.sv
// Shared types and defaults for the regfile write-side logic.
package regfile_pkg;
  localparam int unsigned ADD_WIDTH  = 5;
  localparam int unsigned DATA_WIDTH = 12;

  typedef struct packed {
    logic [ADD_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  localparam logic [ADD_WIDTH-1:0] ZERO_REG = '0;
endpackage

// File: rtl/wb_hazard_match.sv
// Combinational lookup of the youngest pending write to one source register.
module wb_hazard_match
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = 2
) (
  input  wb_entry_t              entries [DEPTH],
  input  logic [DEPTH-1:0]       valid,
  input  logic [PW-1:0]          head,
  input  wb_entry_t              inflight,
  input  logic                   inflight_valid,
  input  logic [ADD_WIDTH-1:0]   q,
  output logic                   hit,
  output logic [DATA_WIDTH-1:0]  data
);

  logic [PW-1:0] idx;

  // Scan oldest to youngest so the last match (youngest) wins; in-flight is oldest of all.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    if (inflight_valid && inflight.rd == q) begin
      hit  = 1'b1;
      data = inflight.data;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && entries[idx].rd == q) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
    if (q == ZERO_REG) begin
      hit  = 1'b0;
      data = '0;
    end
  end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Writeback FIFO draining onto the regfile write port, with hazard/forward lookup.
module regfile_wb_sequencer #(
  parameter int unsigned ADD_WIDTH  = regfile_pkg::ADD_WIDTH,
  parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADD_WIDTH-1:0]       in_rd,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       wb_en,
  output logic [ADD_WIDTH-1:0]       AD3,
  output logic [DATA_WIDTH-1:0]      WD3,
  output logic                       WE3,
  input  logic [ADD_WIDTH-1:0]       q_rs1,
  input  logic [ADD_WIDTH-1:0]       q_rs2,
  output logic                       hit1,
  output logic                       hit2,
  output logic [DATA_WIDTH-1:0]      fwd1,
  output logic [DATA_WIDTH-1:0]      fwd2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  import regfile_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             push;
  logic             pop;
  wb_entry_t        inflight;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready && (in_rd != ZERO_REG);
  assign pop      = (count != '0) && wb_en;
  assign empty    = (count == '0) && !WE3;
  assign inflight = '{rd: AD3, data: WD3};

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{rd: in_rd, data: in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      AD3   <= '0;
      WD3   <= '0;
      WE3   <= 1'b0;
    end else begin
      // push and pop never touch the same slot: push needs count<DEPTH, pop needs count>0
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      if (pop) begin
        AD3         <= mem[head].rd;
        WD3         <= mem[head].data;
        WE3         <= 1'b1;
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end else begin
        WE3 <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  wb_hazard_match #(.DEPTH(DEPTH), .PW(PW)) u_match1 (
    .entries(mem), .valid(valid), .head(head), .inflight(inflight),
    .inflight_valid(WE3), .q(q_rs1), .hit(hit1), .data(fwd1)
  );

  wb_hazard_match #(.DEPTH(DEPTH), .PW(PW)) u_match2 (
    .entries(mem), .valid(valid), .head(head), .inflight(inflight),
    .inflight_valid(WE3), .q(q_rs2), .hit(hit2), .data(fwd2)
  );

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Directed bench for regfile_wb_sequencer with a small regfile reference model.
module tb_regfile_wb_sequencer;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [11:0] in_data;
  logic        wb_en;
  logic [4:0]  AD3;
  logic [11:0] WD3;
  logic        WE3;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        hit1;
  logic        hit2;
  logic [11:0] fwd1;
  logic [11:0] fwd2;
  logic [2:0]  count;
  logic        empty;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  logic [11:0] act_rf [32];
  logic [11:0] exp_rf [32];
  logic [16:0] q_exp [$];

  regfile_wb_sequencer #(.ADD_WIDTH(5), .DATA_WIDTH(12), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .wb_en(wb_en),
    .AD3(AD3), .WD3(WD3), .WE3(WE3), .q_rs1(q_rs1), .q_rs2(q_rs2),
    .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (WE3) pulses <= pulses + 1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) act_rf[i] <= '0;
    end else if (WE3) begin
      act_rf[AD3] <= WD3;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got=%0h exp=0", WE3); end
    checks++; if (AD3 !== 5'd0) begin errors++; $display("FAIL reset_ad3 got=%0h exp=0", AD3); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0h exp=1", empty); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0h exp=1", in_ready); end
    checks++; if (hit1 !== 1'b0 || fwd1 !== 12'h0) begin errors++; $display("FAIL reset_hit1 got=%0h/%0h exp=0/0", hit1, fwd1); end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_drain;
    int p0;
    wb_en = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_rd = 5'(i);
      in_data = 12'(i * 16);
      tick;
    end
    in_valid = 1'b0;
    wb_en = 1'b1;
    q_rs1 = 5'd2;
    tick;
    checks++; if (WE3 !== 1'b1 || AD3 !== 5'd1) begin errors++; $display("FAIL middrain_pre got=%0h/%0h exp=1/1", WE3, AD3); end
    rst = 1'b1;
    #1;
    checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL middrain_we3 got=%0h exp=0", WE3); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL middrain_count got=%0d exp=0", count); end
    checks++; if (hit1 !== 1'b0) begin errors++; $display("FAIL middrain_hit1 got=%0h exp=0", hit1); end
    tick;
    rst = 1'b0;
    p0 = pulses;
    repeat (5) tick;
    checks++; if (pulses !== p0) begin errors++; $display("FAIL middrain_pulses got=%0d exp=%0d", pulses, p0); end
    wb_en = 1'b0;
  endtask

  task automatic test_fill;
    wb_en = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_rd = 5'(i);
      in_data = 12'(i * 17);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got=%0h exp=1", i, in_ready); end
      tick;
    end
    in_rd = 5'd5;
    in_data = 12'h055;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready5 got=%0h exp=0", in_ready); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
    tick;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_hold got=%0d exp=4", count); end
    wb_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick;
      checks++;
      if (WE3 !== 1'b1 || AD3 !== 5'(k) || WD3 !== 12'(k * 17)) begin
        errors++;
        $display("FAIL fill_drain%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, WE3, AD3, WD3, k, k * 17);
      end
      if (k == 2) in_valid = 1'b0;
    end
    tick;
    checks++; if (WE3 !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL fill_end got=%0h/%0h exp=0/1", WE3, empty); end
    wb_en = 1'b0;
  endtask

  task automatic test_x0_drop;
    int p0;
    p0 = pulses;
    wb_en = 1'b1;
    q_rs1 = 5'd0;
    in_valid = 1'b1;
    in_rd = 5'd0;
    in_data = 12'hABC;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%0h exp=1", in_ready); end
    tick;
    in_valid = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL x0_count got=%0d exp=0", count); end
    checks++; if (hit1 !== 1'b0) begin errors++; $display("FAIL x0_hit1 got=%0h exp=0", hit1); end
    repeat (2) tick;
    checks++; if (pulses !== p0) begin errors++; $display("FAIL x0_pulses got=%0d exp=%0d", pulses, p0); end
    wb_en = 1'b0;
  endtask

  task automatic test_fwd_priority;
    wb_en = 1'b0;
    q_rs1 = 5'd7;
    in_valid = 1'b1;
    in_rd = 5'd7;
    in_data = 12'h100;
    tick;
    in_data = 12'h200;
    tick;
    in_valid = 1'b0;
    #1;
    checks++; if (hit1 !== 1'b1 || fwd1 !== 12'h200) begin errors++; $display("FAIL prio_both got=%0h/%0h exp=1/200", hit1, fwd1); end
    wb_en = 1'b1;
    tick;
    wb_en = 1'b0;
    #1;
    checks++; if (hit1 !== 1'b1 || fwd1 !== 12'h200) begin errors++; $display("FAIL prio_after_pop got=%0h/%0h exp=1/200", hit1, fwd1); end
    wb_en = 1'b1;
    tick;
    checks++; if (hit1 !== 1'b1 || fwd1 !== 12'h200) begin errors++; $display("FAIL prio_inflight got=%0h/%0h exp=1/200", hit1, fwd1); end
    tick;
    checks++; if (hit1 !== 1'b0 || fwd1 !== 12'h0) begin errors++; $display("FAIL prio_clear got=%0h/%0h exp=0/0", hit1, fwd1); end
    wb_en = 1'b0;
  endtask

  task automatic test_inflight;
    q_rs2 = 5'd9;
    wb_en = 1'b1;
    in_valid = 1'b1;
    in_rd = 5'd9;
    in_data = 12'h3F0;
    tick;
    in_valid = 1'b0;
    #1;
    checks++; if (hit2 !== 1'b1 || fwd2 !== 12'h3F0) begin errors++; $display("FAIL inflight_queued got=%0h/%0h exp=1/3f0", hit2, fwd2); end
    tick;
    checks++; if (WE3 !== 1'b1 || AD3 !== 5'd9) begin errors++; $display("FAIL inflight_port got=%0h/%0h exp=1/9", WE3, AD3); end
    checks++; if (hit2 !== 1'b1 || fwd2 !== 12'h3F0) begin errors++; $display("FAIL inflight_hit got=%0h/%0h exp=1/3f0", hit2, fwd2); end
    tick;
    checks++; if (hit2 !== 1'b0 || fwd2 !== 12'h0) begin errors++; $display("FAIL inflight_gone got=%0h/%0h exp=0/0", hit2, fwd2); end
    wb_en = 1'b0;
  endtask

  task automatic push_rand;
    logic [4:0]  r;
    logic [11:0] d;
    r = 5'($urandom_range(31, 1));
    d = 12'($urandom);
    in_rd = r;
    in_data = d;
    q_exp.push_back({r, d});
    exp_rf[r] = d;
  endtask

  task automatic test_back_to_back;
    logic [16:0] e;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) exp_rf[i] = '0;
    q_exp.delete();
    wb_en = 1'b0;
    in_valid = 1'b1;
    repeat (2) begin
      push_rand;
      tick;
    end
    wb_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      push_rand;
      tick;
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count%0d got=%0d exp=2", c, count); end
      e = q_exp.pop_front();
      checks++;
      if (WE3 !== 1'b1 || {AD3, WD3} !== e) begin
        errors++;
        $display("FAIL b2b_order%0d got=%0h/%0h/%0h exp=1/%0h/%0h", c, WE3, AD3, WD3, e[16:12], e[11:0]);
      end
    end
    in_valid = 1'b0;
    repeat (2) begin
      tick;
      e = q_exp.pop_front();
      checks++;
      if (WE3 !== 1'b1 || {AD3, WD3} !== e) begin
        errors++;
        $display("FAIL b2b_tail got=%0h/%0h/%0h exp=1/%0h/%0h", WE3, AD3, WD3, e[16:12], e[11:0]);
      end
    end
    tick;
    checks++; if (WE3 !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL b2b_idle got=%0h/%0h exp=0/1", WE3, empty); end
    for (int r = 1; r < 32; r++) begin
      checks++;
      if (act_rf[r] !== exp_rf[r]) begin
        errors++;
        $display("FAIL b2b_rf x%0d got=%0h exp=%0h", r, act_rf[r], exp_rf[r]);
      end
    end
    wb_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_rd = '0;
    in_data = '0;
    wb_en = 1'b0;
    q_rs1 = '0;
    q_rs2 = '0;
    test_reset;
    test_reset_mid_drain;
    test_fill;
    test_x0_drop;
    test_fwd_priority;
    test_inflight;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
